// File: rtl/ifetch_sram.sv
// ifetch_sram: multi-cycle instruction-fetch responder over a valid/ready handshake.
// Define IFETCH_SRAM_RAND_DELAY_EN to replace the fixed LATENCY with an LFSR-chosen 1..4.

package ifetch_sram_pmem_pkg;
  // Simulation memory model behind pmem_read; qword-addressed, unwritten locations read as 0.
  logic [63:0] pmem [logic [63:0]];
  int unsigned pmemReadCount = 0;

  function automatic void pmem_read(input logic [63:0] addr, output logic [63:0] data);
    pmemReadCount++;
    data = pmem.exists(addr) ? pmem[addr] : 64'd0;
  endfunction
endpackage

module ifetch_sram #(
  parameter int LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  input  logic [63:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rerr,
  input  logic        rready
);
  import ifetch_sram_pmem_pkg::*;

  if (LATENCY < 1 || LATENCY > 15) begin : gBadLatency
    $fatal(1, "ifetch_sram: LATENCY=%0d outside legal range 1..15", LATENCY);
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [63:0] addrReg;
  logic [3:0]  count;
  logic [3:0]  loadCount;

  // One qword read per access; bit 2 picks which half is the instruction.
  function automatic logic [31:0] fetchWord(input logic [63:0] addr);
    logic [63:0] rd64;
    pmem_read({addr[63:3], 3'b000}, rd64);
    return addr[2] ? rd64[63:32] : rd64[31:0];
  endfunction

`ifdef IFETCH_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign loadCount = {2'b00, lfsr[1:0]};
`else
  assign loadCount = 4'(LATENCY - 1);
`endif

  // arready is registered, so it only rises one edge after reset release or a response handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rerr    <= 1'b0;
      count   <= 4'd0;
      addrReg <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            addrReg <= araddr;
            count   <= loadCount;
            arready <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            if (addrReg[1:0] == 2'b00) begin
              rdata <= fetchWord(addrReg);
              rerr  <= 1'b0;
            end else begin
              rdata <= 32'd0;
              rerr  <= 1'b1;
            end
            rvalid <= 1'b1;
            state  <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch_sram.md
# ifetch_sram

Instruction-memory responder that answers fetch requests from the instruction fetch stage over a valid/ready address/response handshake. Each accepted 64-bit address becomes one aligned 64-bit read of simulated physical memory through the `pmem_read` DPI-C routine. The responder returns the 32-bit instruction word selected by address bit 2, after a counted access latency. It sits between the fetch stage and the simulation memory model and replaces the fetch stage's direct combinational memory read with a multi-cycle responder.

## Interface
- `LATENCY`, default 1: cycles from request acceptance to `rvalid`; legal range 1..15.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `arvalid`  in  1  fetch request valid.
- `araddr`  in  64  fetch address (instruction PC).
- `arready`  out  1  responder can accept a request.
- `rvalid`  out  1  response valid.
- `rdata`  out  32  instruction word.
- `rerr`  out  1  response carries an error (misaligned address).
- `rready`  in  1  fetch stage accepts the response.

## Operation
- FSM with three states: IDLE, WAIT, RESP.
- IDLE:
  - `arready`=1. On `arvalid & arready`, latch `araddr` into `addrReg`.
  - Load the 4-bit down-counter with latency−1 and go to WAIT.
- WAIT:
  - `arready`=0. Decrement the counter every cycle.
  - On the cycle the counter equals 0, perform the access and go to RESP.
- Access, when `addrReg[1:0]==0`:
  - Call `pmem_read({addrReg[63:3],3'b0}, rd64)` exactly once.
  - `rdata` is `rd64[63:32]` if `addrReg[2]`=1, else `rd64[31:0]`.
  - `rerr`=0.
- Access, when `addrReg[1:0]!=0`: no DPI call; `rdata`=0, `rerr`=1.
- RESP:
  - `rvalid`=1. `rdata` and `rerr` are registered and held stable until `rvalid & rready`.
  - On handshake, go to IDLE.
- There is no same-cycle back-to-back acceptance: `arready` returns to 1 in the cycle after the response handshake.
- `araddr` is ignored outside IDLE. Changes to `araddr` after acceptance have no effect.
- Only one outstanding request at any time; no queue.

## Timing
- Reset values, held while `reset`=0:
  - state=IDLE, `arready`=0, `rvalid`=0, `rdata`=0, `rerr`=0, counter=0.
  - `arready` rises on the first rising edge after `reset` deasserts.
- Latency: request handshake sampled at edge E0 → `rvalid` is 1 after edge E0+L, where L is the effective latency. For `LATENCY`=1, `rvalid` is high in the cycle immediately following the accepting cycle.
- `rvalid` stays 1 for any number of cycles while `rready`=0.
- `rvalid` falls on the edge that samples `rready`=1.
- `rready` asserted before `rvalid` has no effect.
- `arvalid` held with no acceptance is legal. The request is accepted the first cycle `arready`=1.
- Reset mid-operation (WAIT or RESP):
  - All outputs take their reset values immediately (asynchronous).
  - The pending access is discarded and no DPI call is made.
- `LATENCY` outside 1..15 is a configuration error and must trigger a simulation `$fatal` at time 0.

## Configuration
- `IFETCH_SRAM_RAND_DELAY_EN` defined:
  - An 8-bit LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - On each acceptance, the effective latency L = 1 + `lfsr[1:0]`, giving 1..4. `LATENCY` is ignored.
  - The purpose is to stress fetch-stage stall handling.
- Not defined: L = `LATENCY` for every request; no LFSR logic is present.

## Test plan
- Reset release, `LATENCY`=1:
  - `arready`=0 while `reset`=0, 1 one edge after release.
  - `rvalid`/`rdata`/`rerr` are 0 throughout reset.
- Fetch 0x80000000, then 0x80000004, with memory qword at 0x80000000 = 0x00100093_00000413 and `rready` held 1:
  - `rdata`=0x00000413, then 0x00100093.
  - `rvalid` rises exactly one cycle after each acceptance.
- `LATENCY`=5, fetch 0x80000008, `rready`=0 for 3 cycles after `rvalid`:
  - `rvalid` rises 5 cycles after acceptance.
  - `rdata` stays constant over 4 cycles.
  - `arready`=1 only in the cycle after the handshake.
- Fetch 0x80000002: `rerr`=1, `rdata`=0, zero `pmem_read` calls (bench counts calls).
- Assert `reset`=0 two cycles into WAIT with `LATENCY`=8:
  - `rvalid` never rises.
  - The next request after release returns correct data with full latency.
- With `IFETCH_SRAM_RAND_DELAY_EN`, 200 sequential fetches:
  - Every latency is within 1..4, and all four values occur.
  - Data matches the memory model for every fetch.
